// File: rtl/mac_dot_stream_if.sv
// Operand-in / sum-out handshake bundle for mac_dot_stream.
// The engine connects through the slave modport; the feeding logic uses master.
interface mac_dot_stream_if #(
  parameter int A_W   = 4,
  parameter int B_W   = 4,
  parameter int ACC_W = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [A_W-1:0]   in_a;
  logic [B_W-1:0]   in_b;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/mac_dot_stream.sv
// Streaming unsigned dot product: one registered multiply, one accumulate, one sum per N_TERMS pairs.
// Optional MAC_SATURATE_EN: accumulator clamps at all-ones instead of wrapping.
module mac_dot_stream #(
  parameter int A_W     = 4,
  parameter int B_W     = 4,
  parameter int N_TERMS = 16,
  parameter int ACC_W   = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic clr,
  mac_dot_stream_if.slave s,
  output logic busy
);
  localparam int P_W   = A_W + B_W;
  localparam int CNT_W = $clog2(N_TERMS);

  typedef enum logic [1:0] {ACCUM, FLUSH, HOLD} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [P_W-1:0]   prod;
  logic             prod_v;
  logic [ACC_W-1:0] acc;
  logic             sovf;

  logic             in_xfer, out_xfer;
  logic [ACC_W-1:0] add_p;
  logic [ACC_W:0]   sum_raw;
  logic [ACC_W-1:0] sum_res;
  logic             carry;

  assign s.in_ready = ena & ~clr & (state == ACCUM);
  assign in_xfer    = s.in_valid & s.in_ready;
  assign out_xfer   = s.out_valid & s.out_ready & ena;
  assign busy       = (cnt != '0) | (state != ACCUM);

  // One adder serves both the running accumulate and the final FLUSH add.
  assign add_p   = prod_v ? ACC_W'(prod) : '0;
  assign sum_raw = {1'b0, acc} + {1'b0, add_p};
  assign carry   = sum_raw[ACC_W];
`ifdef MAC_SATURATE_EN
  assign sum_res = carry ? '1 : sum_raw[ACC_W-1:0];
`else
  assign sum_res = sum_raw[ACC_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ACCUM;
      cnt         <= '0;
      prod        <= '0;
      prod_v      <= 1'b0;
      acc         <= '0;
      sovf        <= 1'b0;
      s.out_valid <= 1'b0;
      s.out_sum   <= '0;
      s.out_ovf   <= 1'b0;
    end else if (ena) begin
      if (clr) begin
        // Abort: drop the frame but keep the last reported sum visible.
        state       <= ACCUM;
        cnt         <= '0;
        prod_v      <= 1'b0;
        acc         <= '0;
        sovf        <= 1'b0;
        s.out_valid <= 1'b0;
      end else begin
        prod_v <= in_xfer;
        if (in_xfer) prod <= P_W'(s.in_a) * P_W'(s.in_b);
        if (prod_v) begin
          acc  <= sum_res;
          sovf <= sovf | carry;
        end
        case (state)
          ACCUM: begin
            if (in_xfer) begin
              if (cnt == CNT_W'(N_TERMS - 1)) begin
                cnt   <= '0;
                state <= FLUSH;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          FLUSH: begin
            s.out_sum   <= sum_res;
            s.out_ovf   <= sovf | (prod_v & carry);
            s.out_valid <= 1'b1;
            acc         <= '0;
            sovf        <= 1'b0;
            state       <= HOLD;
          end
          HOLD: begin
            if (out_xfer) begin
              s.out_valid <= 1'b0;
              state       <= ACCUM;
            end
          end
          default: state <= ACCUM;
        endcase
      end
    end
  end
endmodule
